// File: rtl/ds_link_rx_if.sv
// Receive-side character handshake between the DS link receiver and the node core.
interface ds_link_rx_if;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ds_link_rx.sv
// IEEE 1355 data-strobe receiver: bit recovery, NULL alignment, character decode,
// parity/escape/disconnect checking and a single holding register toward the core.
//
// state    | meaning
// SEARCH   | hunting for the first NULL, no character alignment yet
// RUN      | aligned, decoding characters
// ESC_SEEN | ESC received, next character must be FCT to form a NULL
module ds_link_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d_in,
  input  logic         s_in,
  input  logic         err_clr,
  ds_link_rx_if.master rx,
  output logic         fct_pulse,
  output logic         got_null,
  output logic         err_parity,
  output logic         err_esc,
  output logic         err_disc,
  output logic         err_overrun
);

  typedef enum logic [1:0] {SEARCH, RUN, ESC_SEEN} state_t;

  localparam logic [6:0] NULL_PAT = 7'b1110100;
  localparam int TMR_W = $clog2(DISC_CYCLES + 1);
  localparam logic [TMR_W-1:0] DISC_LOAD = TMR_W'(DISC_CYCLES - 1);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] d_pipe, s_pipe;
  logic d_sync, s_sync, ds_q, bit_take;
  logic [6:0] win, sh;
  logic [3:0] idx;
  logic p_bit, f_bit, prev_par;
  logic char_last, par_ok;
  logic [1:0] ctrl;
  logic [7:0] data_byte;
  logic null_hit, ld_char, fct_evt, set_par, set_esc, set_disc, set_ovr, link_err;
  logic [8:0] ld_val;
  logic disc_en, disc_hit;
  logic [TMR_W-1:0] disc_tmr;

  assign d_sync    = d_pipe[SYNC_STAGES-1];
  assign s_sync    = s_pipe[SYNC_STAGES-1];
  assign bit_take  = (d_sync ^ s_sync) != ds_q;
  assign char_last = bit_take && (state != SEARCH) && (f_bit ? (idx == 4'd3) : (idx == 4'd9));
  assign par_ok    = prev_par ^ p_bit ^ f_bit;
  // The last bit is still on the wire when the character completes, so decode includes it.
  assign ctrl      = {d_sync, sh[6]};
  assign data_byte = {d_sync, sh};
  assign disc_hit  = disc_en && !bit_take && (disc_tmr == '0);
  assign link_err  = set_par | set_esc | set_disc;
  assign set_ovr   = ld_char && rx.rx_valid && !rx.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    null_hit = 1'b0;
    ld_char  = 1'b0;
    ld_val   = 9'h000;
    fct_evt  = 1'b0;
    set_par  = 1'b0;
    set_esc  = 1'b0;
    set_disc = 1'b0;
    case (state)
      SEARCH: begin
        if (bit_take && ({win[5:0], d_sync} == NULL_PAT)) begin
          null_hit = 1'b1;
          state_nx = RUN;
        end
      end
      RUN, ESC_SEEN: begin
        if (char_last) begin
          if (!par_ok) begin
            set_par  = 1'b1;
            state_nx = SEARCH;
          end else if (state == ESC_SEEN) begin
            if (f_bit && (ctrl == 2'b00)) begin
              state_nx = RUN;
            end else begin
              set_esc  = 1'b1;
              state_nx = SEARCH;
            end
          end else if (!f_bit) begin
            ld_char = 1'b1;
            ld_val  = {1'b0, data_byte};
          end else begin
            case (ctrl)
              2'b00: fct_evt = 1'b1;
              2'b01: begin ld_char = 1'b1; ld_val = 9'h100; end
              2'b10: begin ld_char = 1'b1; ld_val = 9'h101; end
              default: state_nx = ESC_SEEN;
            endcase
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
    if (disc_hit) begin
      set_disc = 1'b1;
      state_nx = SEARCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_pipe      <= '0;
      s_pipe      <= '0;
      ds_q        <= 1'b0;
      win         <= '0;
      sh          <= '0;
      idx         <= '0;
      p_bit       <= 1'b0;
      f_bit       <= 1'b0;
      prev_par    <= 1'b0;
      got_null    <= 1'b0;
      fct_pulse   <= 1'b0;
      err_parity  <= 1'b0;
      err_esc     <= 1'b0;
      err_disc    <= 1'b0;
      err_overrun <= 1'b0;
      rx.rx_data  <= 9'h000;
      rx.rx_valid <= 1'b0;
      disc_en     <= 1'b0;
      disc_tmr    <= '0;
    end else begin
      d_pipe <= {d_pipe[SYNC_STAGES-2:0], d_in};
      s_pipe <= {s_pipe[SYNC_STAGES-2:0], s_in};
      ds_q   <= d_sync ^ s_sync;

      if (state != SEARCH) win <= '0;
      else if (bit_take)   win <= {win[5:0], d_sync};

      if (bit_take && (state != SEARCH)) begin
        idx <= char_last ? 4'd0 : idx + 4'd1;
        if (idx == 4'd0)      p_bit <= d_sync;
        else if (idx == 4'd1) f_bit <= d_sync;
        else                  sh    <= {d_sync, sh[6:1]};
      end else if (state == SEARCH) begin
        idx <= '0;
      end

      if (null_hit)       prev_par <= 1'b0;
      else if (char_last) prev_par <= f_bit ? ^ctrl : ^data_byte;

      if (link_err)      got_null <= 1'b0;
      else if (null_hit) got_null <= 1'b1;

      fct_pulse <= fct_evt;

      // A freshly raised error must not be lost to a coincident clear.
      if (link_err || set_ovr) begin
        err_parity  <= err_parity  | set_par;
        err_esc     <= err_esc     | set_esc;
        err_disc    <= err_disc    | set_disc;
        err_overrun <= err_overrun | set_ovr;
      end else if (err_clr) begin
        err_parity  <= 1'b0;
        err_esc     <= 1'b0;
        err_disc    <= 1'b0;
        err_overrun <= 1'b0;
      end

      if (ld_char && !set_ovr) begin
        rx.rx_data  <= ld_val;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end

      if (bit_take) begin
        disc_en  <= 1'b1;
        disc_tmr <= DISC_LOAD;
      end else if (set_disc) begin
        disc_en <= 1'b0;
      end else if (disc_en && (disc_tmr != '0)) begin
        disc_tmr <= disc_tmr - TMR_W'(1);
      end
    end
  end

endmodule
